// File: rtl/btn_evt_pkg.sv
// Shared event codes and width helpers for the button debounce/event scanner.
package btn_evt_pkg;

  typedef logic [1:0] evt_code_t;

  localparam evt_code_t EVT_NONE    = 2'd0;
  localparam evt_code_t EVT_PRESS   = 2'd1;
  localparam evt_code_t EVT_RELEASE = 2'd2;
  localparam evt_code_t EVT_LONG    = 2'd3;

  function automatic int dcnt_w(input int debc_ticks);
    return $clog2(debc_ticks + 1);
  endfunction

  function automatic int lcnt_w(input int long_ticks);
    return $clog2(long_ticks + 1);
  endfunction

  function automatic int ptr_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/evt_fifo.sv
// Synchronous FIFO with a registered head: a write into an empty FIFO shows at the head 1 clk later.
// Pop only takes effect while the head is valid; a push into a full FIFO is accepted only alongside a pop.
module evt_fifo #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_dat,
  output logic             o_full,
  input  logic             i_pop,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_head_dat
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_cnt;
  logic             r_head_vld;
  logic [WIDTH-1:0] r_head_dat;

  logic             w_full;
  logic             w_pop;
  logic             w_wr;
  logic [AW-1:0]    w_rd_nxt;
  logic [CW-1:0]    w_cnt_pop;

  assign w_full    = (r_cnt == CW'(DEPTH));
  assign w_pop     = i_pop & r_head_vld;
  assign w_wr      = i_push & (~w_full | w_pop);
  assign w_rd_nxt  = w_pop ? r_rd_ptr + AW'(1) : r_rd_ptr;
  assign w_cnt_pop = w_pop ? r_cnt - CW'(1) : r_cnt;

  // Head reloads from the post-pop read slot; a same-cycle write becomes visible next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_cnt      <= '0;
      r_head_vld <= 1'b0;
      r_head_dat <= '0;
    end else begin
      if (w_wr) begin
        r_mem[r_wr_ptr] <= i_push_dat;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      r_rd_ptr   <= w_rd_nxt;
      r_cnt      <= w_cnt_pop + CW'(w_wr);
      r_head_vld <= (w_cnt_pop != '0);
      r_head_dat <= (w_cnt_pop != '0) ? r_mem[w_rd_nxt] : '0;
    end
  end

  assign o_full     = w_full;
  assign o_empty    = ~r_head_vld;
  assign o_head_dat = r_head_dat;

endmodule

// File: rtl/btn_event_ctrl.sv
// Round-robin debounce + long-press scanner for N buttons feeding an event FIFO (valid/ready).
// Events are written 1 clk after the servicing tick; a full FIFO without a pop drops the event and sets evt_ovf.
module btn_event_ctrl
  import btn_evt_pkg::*;
#(
  parameter int N          = 4,
  parameter int TICK_DIV   = 1000,
  parameter int DEBC_TICKS = 10,
  parameter int LONG_TICKS = 500,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         btn_raw,
  output logic [N-1:0]         btn_state,
  output logic                 evt_valid,
  input  logic                 evt_ready,
  output logic [$clog2(N)-1:0] evt_ch,
  output evt_code_t            evt_code,
  output logic                 evt_ovf,
  input  logic                 ovf_clr
);

  localparam int PW = ptr_w(N);
  localparam int DW = dcnt_w(DEBC_TICKS);
  localparam int LW = lcnt_w(LONG_TICKS);
  localparam int TW = $clog2(TICK_DIV);
  localparam int FW = PW + 2;

  logic [N-1:0]  r_sync1;
  logic [N-1:0]  r_sync2;
  logic [TW-1:0] r_pcnt;
  logic [PW-1:0] r_ptr;
  logic [N-1:0]  r_stable;
  logic [DW-1:0] r_dcnt [N];
  logic [LW-1:0] r_lcnt [N];
  logic [N-1:0]  r_long_done;
  logic          r_push_vld;
  logic [PW-1:0] r_push_ch;
  evt_code_t     r_push_code;
  logic          r_ovf;

  logic          w_tick;
  logic          w_sample;
  logic          w_stable;
  logic [DW-1:0] w_dcnt_inc;
  logic [LW-1:0] w_lcnt_inc;
  logic [DW-1:0] w_dcnt_nxt;
  logic [LW-1:0] w_lcnt_nxt;
  logic          w_long_nxt;
  logic          w_flip;
  logic          w_evt;
  evt_code_t     w_evt_code;
  logic          w_full;
  logic          w_empty;
  logic          w_pop;
  logic          w_ovf;
  logic [FW-1:0] w_head;

  assign w_tick     = (r_pcnt == TW'(TICK_DIV - 1));
  assign w_sample   = r_sync2[r_ptr];
  assign w_stable   = r_stable[r_ptr];
  assign w_dcnt_inc = r_dcnt[r_ptr] + DW'(1);
  assign w_lcnt_inc = r_lcnt[r_ptr] + LW'(1);

  // Next state of the channel under the scan pointer; a flip pre-empts the long-press count.
  always_comb begin
    w_dcnt_nxt = '0;
    w_lcnt_nxt = r_lcnt[r_ptr];
    w_long_nxt = r_long_done[r_ptr];
    w_flip     = 1'b0;
    w_evt      = 1'b0;
    w_evt_code = EVT_NONE;
    if (w_sample != w_stable) begin
      if (w_dcnt_inc == DW'(DEBC_TICKS)) begin
        w_flip = 1'b1;
      end else begin
        w_dcnt_nxt = w_dcnt_inc;
      end
    end
    if (w_flip) begin
      w_lcnt_nxt = '0;
      w_long_nxt = 1'b0;
      w_evt      = 1'b1;
      w_evt_code = w_stable ? EVT_RELEASE : EVT_PRESS;
    end else if (w_stable && !r_long_done[r_ptr]) begin
      w_lcnt_nxt = w_lcnt_inc;
      if (w_lcnt_inc == LW'(LONG_TICKS)) begin
        w_long_nxt = 1'b1;
        w_evt      = 1'b1;
        w_evt_code = EVT_LONG;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1     <= '0;
      r_sync2     <= '0;
      r_pcnt      <= '0;
      r_ptr       <= '0;
      r_stable    <= '0;
      r_long_done <= '0;
      for (int i = 0; i < N; i++) begin
        r_dcnt[i] <= '0;
        r_lcnt[i] <= '0;
      end
      r_push_vld  <= 1'b0;
      r_push_ch   <= '0;
      r_push_code <= EVT_NONE;
    end else begin
      r_sync1    <= btn_raw;
      r_sync2    <= r_sync1;
      r_pcnt     <= w_tick ? '0 : r_pcnt + TW'(1);
      r_push_vld <= w_tick & w_evt;
      if (w_tick) begin
        r_ptr              <= (r_ptr == PW'(N - 1)) ? '0 : r_ptr + PW'(1);
        r_stable[r_ptr]    <= w_stable ^ w_flip;
        r_dcnt[r_ptr]      <= w_dcnt_nxt;
        r_lcnt[r_ptr]      <= w_lcnt_nxt;
        r_long_done[r_ptr] <= w_long_nxt;
        r_push_ch          <= r_ptr;
        r_push_code        <= w_evt_code;
      end
    end
  end

  assign w_pop = ~w_empty & evt_ready;
  assign w_ovf = r_push_vld & w_full & ~w_pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_ovf) begin
      r_ovf <= 1'b1;
    end else if (ovf_clr) begin
      r_ovf <= 1'b0;
    end
  end

  evt_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_push     (r_push_vld),
    .i_push_dat ({r_push_ch, r_push_code}),
    .o_full     (w_full),
    .i_pop      (w_pop),
    .o_empty    (w_empty),
    .o_head_dat (w_head)
  );

  assign btn_state = r_stable;
  assign evt_valid = ~w_empty;
  assign evt_ch    = w_head[FW-1:2];
  assign evt_code  = w_head[1:0];
  assign evt_ovf   = r_ovf;

endmodule
